// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: exception codes, interrupt codes, trap FSM states,
// the per-event trap record and the trap vector target calculation.
package trap_ctrl_pkg;

  localparam int TRAP_W = 64;

  typedef enum logic [5:0] {
    EXC_INST_MISALIGN  = 6'd0,
    EXC_INST_FAULT     = 6'd1,
    EXC_ILLEGAL        = 6'd2,
    EXC_BREAKPOINT     = 6'd3,
    EXC_LOAD_MISALIGN  = 6'd4,
    EXC_LOAD_FAULT     = 6'd5,
    EXC_STORE_MISALIGN = 6'd6,
    EXC_STORE_FAULT    = 6'd7,
    EXC_ECALL_U        = 6'd8,
    EXC_ECALL_S        = 6'd9,
    EXC_ECALL_M        = 6'd11,
    EXC_INST_PAGE      = 6'd12,
    EXC_LOAD_PAGE      = 6'd13,
    EXC_STORE_PAGE     = 6'd15
  } rv_trap_t;

  localparam logic [5:0] IRQ_S_SOFT  = 6'd1;
  localparam logic [5:0] IRQ_M_SOFT  = 6'd3;
  localparam logic [5:0] IRQ_S_TIMER = 6'd5;
  localparam logic [5:0] IRQ_M_TIMER = 6'd7;
  localparam logic [5:0] IRQ_S_EXT   = 6'd9;
  localparam logic [5:0] IRQ_M_EXT   = 6'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } trap_state_t;

  typedef struct packed {
    logic              is_int;
    logic [5:0]        code;
    logic [TRAP_W-1:0] epc;
    logic [TRAP_W-1:0] tval;
    logic [TRAP_W-1:0] target;
  } trap_info_t;

  // Vectored mode only applies to interrupts; reserved modes fall back to direct.
  function automatic logic [TRAP_W-1:0] trap_target(input logic [TRAP_W-1:0] mtvec,
                                                    input logic is_int,
                                                    input logic [5:0] code);
    logic [TRAP_W-1:0] base;
    base = {mtvec[TRAP_W-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_int)
      return base + {{(TRAP_W-8){1'b0}}, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Fixed-priority selection among the six architected interrupt lines.
module irq_prio_sel
  import trap_ctrl_pkg::*;
(
  input  logic [15:0] pending,
  output logic        vld,
  output logic [5:0]  code
);

  logic unused_pending;
  assign unused_pending = ^{pending[15:12], pending[10], pending[8], pending[6],
                            pending[4], pending[2], pending[0]};

  always_comb begin
    vld  = 1'b1;
    code = IRQ_M_EXT;
    if (pending[11])     code = IRQ_M_EXT;
    else if (pending[3]) code = IRQ_M_SOFT;
    else if (pending[7]) code = IRQ_M_TIMER;
    else if (pending[9]) code = IRQ_S_EXT;
    else if (pending[1]) code = IRQ_S_SOFT;
    else if (pending[5]) code = IRQ_S_TIMER;
    else begin
      vld  = 1'b0;
      code = '0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: accepts one commit-time event, pulses flush (plus CSR
// write for traps), then holds a frontend redirect until it is accepted.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_exc_vld,
  input  logic [5:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_mret_vld,
  input  logic            i_int_safe,
  input  logic [XLEN-1:0] i_commit_pc,
  input  logic [15:0]     i_mip,
  input  logic [15:0]     i_mie,
  input  logic            i_mstatus_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_busy,
  output logic            o_flush,
  output logic            o_csr_we,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mtval,
  output logic            o_redirect_vld,
  input  logic            i_redirect_rdy,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [31:0]     o_trap_cnt
);

  trap_state_t     state;
  trap_info_t      nxt;
  logic            irq_vld;
  logic [5:0]      irq_code;
  logic            take_exc, take_mret, take_int, take_trap, accept;
  logic [XLEN-1:0] nxt_mcause;
  logic [XLEN-1:0] target;

  irq_prio_sel u_irq_prio_sel (
    .pending (i_mip & i_mie),
    .vld     (irq_vld),
    .code    (irq_code)
  );

  always_comb begin
    take_exc  = i_exc_vld;
    take_mret = !i_exc_vld && i_mret_vld;
    take_int  = !i_exc_vld && !i_mret_vld && i_mstatus_mie && i_int_safe && irq_vld;
    take_trap = take_exc || take_int;
    accept    = take_trap || take_mret;

    nxt = '0;
    if (take_exc) begin
      nxt.code   = i_exc_cause;
      nxt.epc    = TRAP_W'(i_exc_pc);
      nxt.tval   = TRAP_W'(i_exc_tval);
      nxt.target = trap_target(TRAP_W'(i_mtvec), 1'b0, i_exc_cause);
    end else if (take_mret) begin
      nxt.target = TRAP_W'(i_mepc);
    end else begin
      nxt.is_int = 1'b1;
      nxt.code   = irq_code;
      nxt.epc    = TRAP_W'(i_commit_pc);
      nxt.target = trap_target(TRAP_W'(i_mtvec), 1'b1, irq_code);
    end

    nxt_mcause = XLEN'(nxt.code);
    nxt_mcause[XLEN-1] = nxt.is_int;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      target         <= '0;
      o_busy         <= 1'b0;
      o_flush        <= 1'b0;
      o_csr_we       <= 1'b0;
      o_mcause       <= '0;
      o_mepc         <= '0;
      o_mtval        <= '0;
      o_redirect_vld <= 1'b0;
      o_redirect_pc  <= '0;
      o_trap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_FLUSH;
            target   <= XLEN'(nxt.target);
            o_busy   <= 1'b1;
            o_flush  <= 1'b1;
            o_csr_we <= take_trap;
            if (take_trap) begin
              o_mcause   <= nxt_mcause;
              o_mepc     <= XLEN'(nxt.epc);
              o_mtval    <= XLEN'(nxt.tval);
              o_trap_cnt <= o_trap_cnt + 32'd1;
            end
          end
        end
        // One-cycle flush pulse, then present the redirect.
        ST_FLUSH: begin
          state          <= ST_REDIRECT;
          o_flush        <= 1'b0;
          o_csr_we       <= 1'b0;
          o_redirect_vld <= 1'b1;
          o_redirect_pc  <= target;
        end
        ST_REDIRECT: begin
          if (i_redirect_rdy) begin
            state          <= ST_IDLE;
            o_redirect_vld <= 1'b0;
            o_busy         <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl with directed corner scenarios.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_vld, mret_vld, int_safe, mstatus_mie, redirect_rdy;
  logic [5:0]  exc_cause;
  logic [63:0] exc_pc, exc_tval, commit_pc, mtvec, mepc;
  logic [15:0] mip, mie;
  logic        busy, flush, csr_we, redirect_vld;
  logic [63:0] mcause, mepc_o, mtval, redirect_pc;
  logic [31:0] trap_cnt;

  trap_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .i_exc_vld(exc_vld), .i_exc_cause(exc_cause), .i_exc_pc(exc_pc), .i_exc_tval(exc_tval),
    .i_mret_vld(mret_vld), .i_int_safe(int_safe), .i_commit_pc(commit_pc),
    .i_mip(mip), .i_mie(mie), .i_mstatus_mie(mstatus_mie),
    .i_mtvec(mtvec), .i_mepc(mepc),
    .o_busy(busy), .o_flush(flush), .o_csr_we(csr_we),
    .o_mcause(mcause), .o_mepc(mepc_o), .o_mtval(mtval),
    .o_redirect_vld(redirect_vld), .i_redirect_rdy(redirect_rdy),
    .o_redirect_pc(redirect_pc), .o_trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          trap;
    logic [63:0] mcause;
    logic [63:0] mepc;
    logic [63:0] mtval;
    logic [63:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          have_cur = 1'b0;
  logic [31:0] m_cnt = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  // Reference model: architectural trap rules applied to the current inputs.
  task automatic predict(output bit taken);
    int          prio [6] = '{11, 3, 7, 9, 1, 5};
    exp_t        e;
    logic [63:0] base;
    bit          found;
    base  = {mtvec[63:2], 2'b00};
    taken = 1'b0;
    e     = '{default: '0};
    if (exc_vld) begin
      taken    = 1'b1;
      e.trap   = 1'b1;
      e.mcause = 64'(exc_cause);
      e.mepc   = exc_pc;
      e.mtval  = exc_tval;
      e.pc     = base;
    end else if (mret_vld) begin
      taken = 1'b1;
      e.pc  = mepc;
    end else if (mstatus_mie && int_safe) begin
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (!found && mip[prio[i]] && mie[prio[i]]) begin
          found    = 1'b1;
          taken    = 1'b1;
          e.trap   = 1'b1;
          e.mcause = (64'd1 << 63) | 64'(prio[i]);
          e.mepc   = commit_pc;
          e.mtval  = 64'd0;
          e.pc     = (mtvec[1:0] == 2'b01) ? base + 64'(4 * prio[i]) : base;
        end
      end
    end
    if (e.trap) m_cnt = m_cnt + 32'd1;
    e.cnt = m_cnt;
    if (taken) q.push_back(e);
  endtask

  task automatic clear_events();
    exc_vld = 1'b0; mret_vld = 1'b0; mip = '0; mie = '0;
    mstatus_mie = 1'b0; int_safe = 1'b0;
  endtask

  // Events that would be taken if the DUT were idle; it must ignore them.
  task automatic garbage();
    exc_vld     = 1'($urandom_range(0, 1));
    mret_vld    = 1'($urandom_range(0, 1));
    exc_cause   = 6'($urandom_range(0, 15));
    mip         = 16'($urandom);
    mie         = 16'hFFFF;
    mstatus_mie = 1'b1;
    int_safe    = 1'b1;
    exc_pc      = {$urandom, $urandom};
    commit_pc   = {$urandom, $urandom};
    mepc        = {$urandom, $urandom};
    mtvec       = {$urandom, $urandom};
  endtask

  task automatic launch(output bit taken);
    predict(taken);
    @(posedge clk); #1;
    if (taken) garbage();
    else clear_events();
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!redirect_vld && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!redirect_vld) chk("redirect_timeout", 64'(redirect_vld), 64'd1);
  endtask

  task automatic finish(input int delay, output int vcyc);
    vcyc = 0;
    redirect_rdy = 1'b0;
    wait_vld();
    if (redirect_vld) vcyc = 1;
    repeat (delay) begin
      @(posedge clk); #1;
      if (redirect_vld) vcyc++;
    end
    redirect_rdy = 1'b1;
    @(posedge clk); #1;
    redirect_rdy = 1'b0;
    clear_events();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_redirect_vld", 64'(redirect_vld), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (flush) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL flush_unexpected: got flush=1 expected no event");
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("csr_we", 64'(csr_we), 64'(cur.trap));
          if (cur.trap) begin
            chk("mcause", mcause, cur.mcause);
            chk("mepc", mepc_o, cur.mepc);
            chk("mtval", mtval, cur.mtval);
          end
          chk("trap_cnt", 64'(trap_cnt), 64'(cur.cnt));
          chk("busy_flush", 64'(busy), 64'd1);
        end
      end else if (csr_we) begin
        chk("csr_we_outside_flush", 64'(csr_we), 64'd0);
      end
      if (redirect_vld) begin
        if (!have_cur) chk("redirect_without_event", 64'(redirect_vld), 64'd0);
        else chk("redirect_pc", redirect_pc, cur.pc);
        chk("busy_redirect", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit taken;
    int vcyc;
    rst = 1'b0; redirect_rdy = 1'b0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; commit_pc = '0; mtvec = '0; mepc = '0;
    clear_events();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_csr_we", 64'(csr_we), 64'd0);
    chk("rst_redirect_vld", 64'(redirect_vld), 64'd0);
    chk("rst_trap_cnt", 64'(trap_cnt), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Exception into vectored mtvec still targets base
    exc_vld = 1'b1; exc_cause = 6'd2; exc_pc = 64'h8000_0010; exc_tval = 64'h13;
    mtvec = 64'h8000_1001;
    launch(taken); finish(1, vcyc);

    // Vectored machine external interrupt
    mip = 16'h0888; mie = 16'h0888; mstatus_mie = 1'b1; int_safe = 1'b1;
    commit_pc = 64'h8000_0040; mtvec = 64'h8000_1001;
    launch(taken); finish(0, vcyc);

    // Exception beats mret and pending timer
    exc_vld = 1'b1; exc_cause = 6'd5; mret_vld = 1'b1; exc_pc = 64'h8000_0100;
    exc_tval = 64'hDEAD; mip = 16'h0080; mie = 16'h0080; mstatus_mie = 1'b1; int_safe = 1'b1;
    mtvec = 64'h8000_2000; mepc = 64'h1234;
    launch(taken); finish(2, vcyc);

    // mret with a stalled frontend
    mret_vld = 1'b1; mepc = 64'h8000_0200;
    launch(taken); finish(3, vcyc);
    chk("mret_vld_cycles", 64'(vcyc), 64'd4);

    // Reset while redirect is pending
    exc_vld = 1'b1; exc_cause = 6'd7; exc_pc = 64'h9000_0000; exc_tval = 64'h1; mtvec = 64'h8000_3000;
    launch(taken);
    wait_vld();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_flush", 64'(flush), 64'd0);
    chk("midrst_csr_we", 64'(csr_we), 64'd0);
    chk("midrst_redirect_vld", 64'(redirect_vld), 64'd0);
    chk("midrst_redirect_pc", redirect_pc, 64'd0);
    chk("midrst_mcause", mcause, 64'd0);
    chk("midrst_mepc", mepc_o, 64'd0);
    chk("midrst_mtval", mtval, 64'd0);
    chk("midrst_trap_cnt", 64'(trap_cnt), 64'd0);
    m_cnt = '0;
    clear_events();
    rst = 1'b1;
    @(posedge clk); #1;
    exc_vld = 1'b1; exc_cause = 6'd11; exc_pc = 64'h8000_0300; exc_tval = 64'h0; mtvec = 64'h8000_0003;
    launch(taken); finish(0, vcyc);

    // Counter wrap via backdoor preload
    @(negedge clk);
    force dut.o_trap_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.o_trap_cnt;
    m_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    exc_vld = 1'b1; exc_cause = 6'd1; exc_pc = 64'h8000_0400; exc_tval = 64'h55; mtvec = 64'h8000_4000;
    launch(taken); finish(0, vcyc);

    for (int i = 0; i < 150; i++) begin
      exc_vld     = ($urandom_range(0, 3) == 0);
      mret_vld    = ($urandom_range(0, 3) == 0);
      exc_cause   = 6'($urandom_range(0, 15));
      exc_pc      = {$urandom, $urandom};
      exc_tval    = {$urandom, $urandom};
      commit_pc   = {$urandom, $urandom};
      mepc        = {$urandom, $urandom};
      mtvec       = {$urandom, $urandom};
      mip         = 16'($urandom);
      mie         = 16'($urandom);
      mstatus_mie = 1'($urandom_range(0, 1));
      int_safe    = 1'($urandom_range(0, 1));
      launch(taken);
      if (taken) finish($urandom_range(0, 3), vcyc);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL expose parameter XLEN, default 64, machine register width.
REQ-002 SHALL expose clk  input  1  single core clock.
REQ-003 SHALL expose rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL expose i_exc_vld  input  1  ROB head commits with a pending exception.
REQ-005 SHALL expose i_exc_cause  input  6  rv_trap_t::exception code.
REQ-006 SHALL expose i_exc_pc, i_exc_tval  input  XLEN each  faulting pc; trap value.
REQ-007 SHALL expose i_mret_vld  input  1  ROB head commits mret.
REQ-008 SHALL expose i_int_safe  input  1  ROB at instruction boundary; interrupt may be taken.
REQ-009 SHALL expose i_commit_pc  input  XLEN  pc of next instruction to commit (interrupt mepc).
REQ-010 SHALL expose i_mip, i_mie  input  16 each  pending and enable bits.
REQ-011 SHALL expose i_mstatus_mie  input  1  global interrupt enable.
REQ-012 SHALL expose i_mtvec, i_mepc  input  XLEN each  current CSR values.
REQ-013 SHALL expose o_busy  output  1  stalls ROB commit.
REQ-014 SHALL expose o_flush  output  1  pipeline flush pulse.
REQ-015 SHALL expose o_csr_we  output  1  write mcause/mepc/mtval this cycle.
REQ-016 SHALL expose o_mcause, o_mepc, o_mtval  output  XLEN each  CSR write data.
REQ-017 SHALL expose o_redirect_vld  output  1; i_redirect_rdy  input  1; o_redirect_pc  output  XLEN  frontend redirect handshake.
REQ-018 SHALL expose o_trap_cnt  output  32  count of traps taken (exceptions + interrupts).

Function
REQ-019 States SHALL be IDLE, FLUSH, REDIRECT; FLUSH lasts exactly one cycle.
REQ-020 Events SHALL be sampled only in IDLE; all event inputs are ignored in FLUSH/REDIRECT.
REQ-021 Priority SHALL be exception > mret > interrupt when several are asserted in the same cycle.
REQ-022 An interrupt SHALL be taken only if i_mstatus_mie=1, i_int_safe=1, and (i_mip & i_mie) != 0.
REQ-023 Interrupt selection SHALL be fixed priority mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5); all other bits are ignored.
REQ-024 On acceptance at cycle T, the block SHALL register the event info and enter FLUSH at T+1.
REQ-025 In FLUSH, o_flush=1; for traps, o_csr_we=1 is also asserted in the same cycle.
REQ-026 For exceptions: mcause={0,zero-extended code}, mepc=i_exc_pc, mtval=i_exc_tval.
REQ-027 For interrupts: mcause={1 at bit XLEN-1, code}, mepc=i_commit_pc, mtval=0.
REQ-028 For mret, o_csr_we SHALL stay 0 and redirect pc SHALL be i_mepc sampled at acceptance.
REQ-029 Trap target base SHALL be {i_mtvec[XLEN-1:2],2'b00}.
REQ-030 mtvec mode 1 with an interrupt SHALL target base+4*code; every other case (including modes 2 and 3) SHALL target base.
REQ-031 In REDIRECT, o_redirect_vld SHALL hold with a stable pc until i_redirect_rdy=1, then return to IDLE next cycle.
REQ-032 o_busy SHALL be 1 in FLUSH and REDIRECT and 0 in IDLE.
REQ-033 o_trap_cnt SHALL increment by 1 per accepted trap (not mret), wrapping 0xFFFFFFFF->0.

Reset
REQ-034 rst=0 at a clock edge SHALL force IDLE, o_trap_cnt=0, and all outputs 0, including mid-FLUSH or mid-REDIRECT; the in-flight event is discarded.

Structure
REQ-035 The trap state enum and a trapInfo struct (is_int, code, epc, tval, target) SHALL live in the shared core package beside rv_trap_t.
REQ-036 Interrupt priority selection SHALL be a combinational sub-module irq_prio_sel (16-bit pending in, valid + 6-bit code out).

Verification
REQ-037 exc_vld, cause=2, pc=0x80000010, tval=0x13, mtvec=0x80001001 -> FLUSH at T+1 with mcause=2, mepc=0x80000010, mtval=0x13; redirect pc=0x80001000.
REQ-038 mip=mie=0x0888, mstatus_mie=1, int_safe=1, mtvec=0x80001001 -> mcause=(1<<63)|11, redirect pc=0x8000102C, mtval=0.
REQ-039 exc_vld(cause=5) and mret_vld in the same cycle as a pending mTimer -> exception taken; only one FLUSH pulse; trap_cnt +1.
REQ-040 mret with mepc=0x80000200, i_redirect_rdy held 0 for 3 cycles -> redirect_vld stable for 4 cycles with pc 0x80000200; csr_we never 1; trap_cnt unchanged.
REQ-041 rst=0 during REDIRECT -> next cycle all outputs 0 and state IDLE; a new exception is then accepted normally.
REQ-042 Preload o_trap_cnt=0xFFFFFFFF via 2^32-1 traps or backdoor, then take one trap -> o_trap_cnt=0.
